multi_cycle_datapath: RTL

MULTI_CYCLE_DATAPATH -- requirements
Module: multi_cycle_datapath

---
 rtl/multi_cycle_datapath_pkg.sv | 35 +++
 rtl/multi_cycle_datapath_if.sv | 39 +++
 rtl/multi_cycle_datapath_alu.sv | 30 +++
 rtl/multi_cycle_datapath.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_datapath_pkg.sv
// Shared types for the multi-cycle datapath: FSM state encoding, operation kinds
// and ALU control codes.
package multi_cycle_datapath_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_RTYPE = 2'b00,
        OP_ITYPE = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_kind_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // True for the six ALU control codes the datapath implements.
    function automatic logic func_is_legal(input logic [3:0] f);
        case (f)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_datapath_if.sv
// Operation handshake and completion bus of the multi-cycle datapath.
// The err signal exists only when MULTI_CYCLE_DATAPATH_ILLEGAL_FUNC_EN is defined.
interface multi_cycle_datapath_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_kind;
    logic [3:0]        func;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [15:0]       imm;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              busy;
`ifdef MULTI_CYCLE_DATAPATH_ILLEGAL_FUNC_EN
    logic              err;
`endif

    modport master (
        output op_valid, op_kind, func, rs, rt, rd, imm,
        input  op_ready, done, result, zero, busy
`ifdef MULTI_CYCLE_DATAPATH_ILLEGAL_FUNC_EN
        , input err
`endif
    );

    modport slave (
        input  op_valid, op_kind, func, rs, rt, rd, imm,
        output op_ready, done, result, zero, busy
`ifdef MULTI_CYCLE_DATAPATH_ILLEGAL_FUNC_EN
        , output err
`endif
    );

endinterface

// File: rtl/multi_cycle_datapath_alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT/NOR; any other control code computes ADD.
module mdp_alu
    import multi_cycle_datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        ctl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] out,
    output logic              zero
);

    // Function select; SLT compares as two's-complement.
    always_comb begin
        out = {DATA_W{1'b0}};
        case (ctl)
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_SLT: out = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: out = ~(a | b);
            default: out = a + b;
        endcase
    end

    assign zero = (out == {DATA_W{1'b0}});

endmodule

// File: rtl/multi_cycle_datapath.sv
// Five-state multi-cycle datapath with inline register file and data memory.
// Optional MULTI_CYCLE_DATAPATH_ILLEGAL_FUNC_EN flags and suppresses unlisted ALU codes.
module multi_cycle_datapath
    import multi_cycle_datapath_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multi_cycle_datapath_if.slave bus
);

    localparam int NREGS  = 1 << REG_AW;
    localparam int NWORDS = 1 << MEM_AW;

    state_t            state_r;
    state_t            state_nx_s;
    op_kind_t          kind_r;
    logic [3:0]        func_r;
    logic [REG_AW-1:0] rs_r;
    logic [REG_AW-1:0] rt_r;
    logic [REG_AW-1:0] rd_r;
    logic [15:0]       imm_r;

    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] alu_r;
    logic              alu_zero_r;
    logic [DATA_W-1:0] mdr_r;
    logic              done_r;
    logic [DATA_W-1:0] result_r;
    logic              zero_r;

    logic [DATA_W-1:0] regs_r [NREGS];
    logic [DATA_W-1:0] mem_r  [NWORDS];

    logic              accept_s;
    logic              is_mem_s;
    logic              illegal_s;
    logic              mem_we_s;
    logic              reg_we_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic [DATA_W-1:0] sext_s;
    logic [3:0]        alu_ctl_s;
    logic [DATA_W-1:0] alu_out_s;
    logic              alu_zero_s;
    logic [REG_AW-1:0] wb_addr_s;
    logic [DATA_W-1:0] wb_data_s;
    logic [MEM_AW-1:0] addr_s;

    assign accept_s  = bus.op_valid && (state_r == S_IDLE);
    assign is_mem_s  = (kind_r == OP_LOAD) || (kind_r == OP_STORE);
    assign rs_val_s  = (rs_r == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[rs_r];
    assign rt_val_s  = (rt_r == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[rt_r];
    assign sext_s    = {{(DATA_W-16){imm_r[15]}}, imm_r};
    assign alu_ctl_s = is_mem_s ? ALU_ADD : func_r;
    assign addr_s    = alu_r[MEM_AW-1:0];
    assign wb_addr_s = (kind_r == OP_RTYPE) ? rd_r : rt_r;
    assign wb_data_s = (kind_r == OP_LOAD) ? mdr_r : alu_r;

`ifdef MULTI_CYCLE_DATAPATH_ILLEGAL_FUNC_EN
    logic err_r;
    assign illegal_s = !is_mem_s && !func_is_legal(func_r);
    assign bus.err   = err_r;
`else
    assign illegal_s = 1'b0;
`endif

    mdp_alu #(.DATA_W(DATA_W)) u_alu (
        .ctl  (alu_ctl_s),
        .a    (a_r),
        .b    (b_r),
        .out  (alu_out_s),
        .zero (alu_zero_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic and the memory/register write strobes.
    always_comb begin
        state_nx_s = state_r;
        mem_we_s   = 1'b0;
        reg_we_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nx_s = S_DECODE;
                else          state_nx_s = S_IDLE;
            end
            S_DECODE: state_nx_s = S_EXEC;
            S_EXEC: begin
                if (is_mem_s) state_nx_s = S_MEM;
                else          state_nx_s = S_WB;
            end
            S_MEM: begin
                state_nx_s = S_WB;
                // Reset in the same cycle must not let the store land.
                if (kind_r == OP_STORE) mem_we_s = rst_n;
                else                    mem_we_s = 1'b0;
            end
            S_WB: begin
                state_nx_s = S_IDLE;
                if ((kind_r != OP_STORE) && !illegal_s) reg_we_s = 1'b1;
                else                                    reg_we_s = 1'b0;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Operation fields are captured only on the accepting handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kind_r <= OP_RTYPE;
            func_r <= 4'b0000;
            rs_r   <= {REG_AW{1'b0}};
            rt_r   <= {REG_AW{1'b0}};
            rd_r   <= {REG_AW{1'b0}};
            imm_r  <= 16'h0000;
        end else if (accept_s) begin
            kind_r <= op_kind_t'(bus.op_kind);
            func_r <= bus.func;
            rs_r   <= bus.rs;
            rt_r   <= bus.rt;
            rd_r   <= bus.rd;
            imm_r  <= bus.imm;
        end
    end

    // Operand, ALU and memory-data pipeline latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r        <= {DATA_W{1'b0}};
            b_r        <= {DATA_W{1'b0}};
            alu_r      <= {DATA_W{1'b0}};
            alu_zero_r <= 1'b0;
            mdr_r      <= {DATA_W{1'b0}};
        end else begin
            if (state_r == S_DECODE) begin
                a_r <= rs_val_s;
                b_r <= (kind_r == OP_RTYPE) ? rt_val_s : sext_s;
            end
            if (state_r == S_EXEC) begin
                alu_r      <= alu_out_s;
                alu_zero_r <= alu_zero_s;
            end
            if ((state_r == S_MEM) && (kind_r == OP_LOAD)) begin
                mdr_r <= mem_r[addr_s];
            end
        end
    end

    // Register file; entry 0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (reg_we_s && (wb_addr_s != {REG_AW{1'b0}})) begin
            regs_r[wb_addr_s] <= wb_data_s;
        end
    end

    // Data memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[addr_s] <= rt_val_s;
        end
    end

    // Completion outputs, updated as the write-back state retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_r   <= 1'b0;
            result_r <= {DATA_W{1'b0}};
            zero_r   <= 1'b0;
`ifdef MULTI_CYCLE_DATAPATH_ILLEGAL_FUNC_EN
            err_r    <= 1'b0;
`endif
        end else begin
            done_r <= (state_r == S_WB);
`ifdef MULTI_CYCLE_DATAPATH_ILLEGAL_FUNC_EN
            err_r  <= (state_r == S_WB) && illegal_s;
`endif
            if (state_r == S_WB) begin
                result_r <= illegal_s ? {DATA_W{1'b0}} : wb_data_s;
                zero_r   <= alu_zero_r;
            end
        end
    end

    assign bus.op_ready = (state_r == S_IDLE);
    assign bus.busy     = (state_r != S_IDLE);
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.zero     = zero_r;

endmodule
